id_ex_register: RTL and testbench
=================================

Name: id_ex_register

Overview:
- Pipeline register between decode and execute.
- Captures the decode-stage control bundle produced by the control unit, plus register-file data, immediate, PC and register addresses, and presents them to the execute stage one cycle later.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width of register data, immediate and PC fields.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- FlushE  in  1  replace the next execute-stage contents with a bubble
- StallE  in  1  hold current execute-stage contents
- ValidD  in  1  decode slot holds a real instruction
- RegWriteD / RegWriteE  in/out  1  register-file write enable
- ResultSrcD / ResultSrcE  in/out  2  writeback select: 00 ALU, 01 mem, 10 PC+4, 11 immediate
- MemWriteD / MemWriteE  in/out  1  store enable
- JumpD / JumpE  in/out  1  jal or jalr
- BranchD / BranchE  in/out  1  conditional branch
- bne_selD / bne_selE  in/out  1  branch is bne
- lui_selD / lui_selE  in/out  1  instruction is lui
- jalr_selD / jalr_selE  in/out  1  instruction is jalr
- ALUControlD / ALUControlE  in/out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt
- ALUSrcD / ALUSrcE  in/out  1  ALU B operand select
- RD1D / RD1E, RD2D / RD2E  in/out  XLEN  register-file read data
- PCD / PCE, PCPlus4D / PCPlus4E  in/out  XLEN  instruction PC and PC+4
- ImmExtD / ImmExtE  in/out  XLEN  extended immediate
- Rs1D / Rs1E, Rs2D / Rs2E, RdD / RdE  in/out  5  register addresses, used by forwarding
- ValidE  out  1  execute slot holds a real instruction
- BubbleCount  out  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- Every E output is a register; there is no combinational path from any D input to any E output.
- Reset: while rst=1, all E outputs, ValidE and BubbleCount are 0, asynchronously. Releasing rst is synchronous to clk, and the first capture happens on the first edge with rst=0.
- Update priority at each rising edge:
  - rst over FlushE over StallE over normal load.
  - FlushE=1: bubble. All E outputs are 0, including RegWriteE, MemWriteE, JumpE, BranchE and ValidE; data and address fields are also 0. Flush wins even if StallE=1.
  - StallE=1, FlushE=0: all E registers and ValidE keep their values.
  - Otherwise: every E output takes its D input on the edge, and ValidE takes ValidD. Latency is exactly 1 cycle.
- An all-zero bundle must be architecturally inert: no register write, no store, no branch, no jump. The execute stage relies on this.
- Bubble counter:
  - Increments by 1 on every edge where FlushE=1 and rst=0, whether or not StallE is set.
  - Also increments on an edge where StallE=0, FlushE=0 and ValidD=0 (an implicit bubble propagates).
  - Saturates at 2^CNT_W-1 and never wraps. It is not affected by StallE alone.
- Simultaneous events: FlushE and StallE together give flush plus a single increment. rst asserted mid-cycle clears everything immediately, regardless of FlushE or StallE.
- X-safety: inputs are don't-care during flush or stall. Outputs must not propagate X from D inputs in those cycles.

Test Plan:
- Reset: assert rst mid-cycle with the E registers loaded (RegWriteE=1, RD1E=32'hDEADBEEF) → all outputs 0 immediately, before the next edge; BubbleCount=0.
- Normal load: present add x3,x1,x2 (RegWriteD=1, ALUControlD=000, Rs1D=1, Rs2D=2, RdD=3, RD1D=5, RD2D=7, ValidD=1) → the next edge shows identical E values with ValidE=1, and BubbleCount is unchanged.
- Stall: load sw (MemWriteD=1, ALUSrcD=1, ImmExtD=8), then StallE=1 for 3 cycles while the D inputs change → E holds MemWriteE=1, ImmExtE=8 for all 3 cycles, and BubbleCount is unchanged.
- Flush: with E holding a beq (BranchE=1, ALUControlE=001), pulse FlushE one cycle → all E outputs 0 and ValidE=0; BubbleCount increments by 1. On the next edge, loading jal (JumpD=1, ResultSrcD=10) → JumpE=1, ResultSrcE=10.
- Flush+stall: FlushE=1 and StallE=1 on the same edge → a bubble is inserted, not held; BubbleCount increments by 1.
- Saturation: CNT_W=4, hold FlushE=1 for 20 edges → BubbleCount reaches 15 and stays at 15; ValidE stays 0 throughout.

Source files
------------

// File: rtl/id_ex_register.sv
// Decode-to-execute pipeline register with stall hold, flush bubble insertion
// and a saturating bubble counter for performance debug.
module id_ex_register #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FlushE,
  input  logic             StallE,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             bne_selD,
  input  logic             lui_selD,
  input  logic             jalr_selD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             RegWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             bne_selE,
  output logic             lui_selE,
  output logic             jalr_selE,
  output logic [2:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic [CNT_W-1:0] BubbleCount
);

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            bne_sel;
    logic            lui_sel;
    logic            jalr_sel;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
  } ex_bundle_t;

  ex_bundle_t       w_d;
  ex_bundle_t       r_e;
  logic             w_bubble;
  logic [CNT_W-1:0] r_bubble_cnt;

  assign w_d = '{
    reg_write:   RegWriteD,
    result_src:  ResultSrcD,
    mem_write:   MemWriteD,
    jump:        JumpD,
    branch:      BranchD,
    bne_sel:     bne_selD,
    lui_sel:     lui_selD,
    jalr_sel:    jalr_selD,
    alu_control: ALUControlD,
    alu_src:     ALUSrcD,
    rd1:         RD1D,
    rd2:         RD2D,
    pc:          PCD,
    pc_plus4:    PCPlus4D,
    imm_ext:     ImmExtD,
    rs1:         Rs1D,
    rs2:         Rs2D,
    rd:          RdD,
    valid:       ValidD
  };

  // Flush loads constant zero and stall recirculates, so D-side X never reaches E then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_e <= '0;
    else if (FlushE)
      r_e <= '0;
    else if (!StallE)
      r_e <= w_d;
  end

  // Explicit flush, or an empty decode slot moving forward, both count as a bubble.
  assign w_bubble = FlushE | (~StallE & ~ValidD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_bubble_cnt <= '0;
    else if (w_bubble && (r_bubble_cnt != '1))
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
  end

  assign RegWriteE   = r_e.reg_write;
  assign ResultSrcE  = r_e.result_src;
  assign MemWriteE   = r_e.mem_write;
  assign JumpE       = r_e.jump;
  assign BranchE     = r_e.branch;
  assign bne_selE    = r_e.bne_sel;
  assign lui_selE    = r_e.lui_sel;
  assign jalr_selE   = r_e.jalr_sel;
  assign ALUControlE = r_e.alu_control;
  assign ALUSrcE     = r_e.alu_src;
  assign RD1E        = r_e.rd1;
  assign RD2E        = r_e.rd2;
  assign PCE         = r_e.pc;
  assign PCPlus4E    = r_e.pc_plus4;
  assign ImmExtE     = r_e.imm_ext;
  assign Rs1E        = r_e.rs1;
  assign Rs2E        = r_e.rs2;
  assign RdE         = r_e.rd;
  assign ValidE      = r_e.valid;
  assign BubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: a reference model pushes expected E state
// into a scoreboard queue as each step is driven; entries are popped after the edge.
module tb_id_ex_register;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic            MemWrite;
    logic            Jump;
    logic            Branch;
    logic            bne_sel;
    logic            lui_sel;
    logic            jalr_sel;
    logic [2:0]      ALUControl;
    logic            ALUSrc;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] ImmExt;
    logic [4:0]      Rs1;
    logic [4:0]      Rs2;
    logic [4:0]      Rd;
    logic            Valid;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  typedef struct {
    string            tag;
    bundle_t          e;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic FlushE = 1'b0;
  logic StallE = 1'b0;
  bundle_t d = '0;

  logic             RegWriteE, MemWriteE, JumpE, BranchE, bne_selE, lui_selE;
  logic             jalr_selE, ALUSrcE, ValidE;
  logic [1:0]       ResultSrcE;
  logic [2:0]       ALUControlE;
  logic [XLEN-1:0]  RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [CNT_W-1:0] BubbleCount;
  bundle_t          obs;

  assign obs = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, bne_selE, lui_selE,
                jalr_selE, ALUControlE, ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
                Rs1E, Rs2E, RdE, ValidE};

  id_ex_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .StallE(StallE), .ValidD(d.Valid),
    .RegWriteD(d.RegWrite), .ResultSrcD(d.ResultSrc), .MemWriteD(d.MemWrite),
    .JumpD(d.Jump), .BranchD(d.Branch), .bne_selD(d.bne_sel), .lui_selD(d.lui_sel),
    .jalr_selD(d.jalr_sel), .ALUControlD(d.ALUControl), .ALUSrcD(d.ALUSrc),
    .RD1D(d.RD1), .RD2D(d.RD2), .PCD(d.PC), .PCPlus4D(d.PCPlus4), .ImmExtD(d.ImmExt),
    .Rs1D(d.Rs1), .Rs2D(d.Rs2), .RdD(d.Rd),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .bne_selE(bne_selE), .lui_selE(lui_selE),
    .jalr_selE(jalr_selE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .BubbleCount(BubbleCount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  exp_t q[$];
  bundle_t m_e = '0;
  int unsigned m_cnt = 0;

  task automatic check(input string tag, input bundle_t exp_e, input logic [CNT_W-1:0] exp_cnt);
    n_cmp++;
    assert (obs === exp_e) else begin
      n_mis++;
      $error("FAIL %s.bundle: observed %h expected %h", tag, obs, exp_e);
    end
    n_cmp++;
    assert (BubbleCount === exp_cnt) else begin
      n_mis++;
      $error("FAIL %s.count: observed %0d expected %0d", tag, BubbleCount, exp_cnt);
    end
  endtask

  // Drive one edge: model the next E state, queue it, clock, then compare.
  task automatic step(input logic fl, input logic st, input string tag);
    exp_t ex;
    FlushE = fl;
    StallE = st;
    if (fl) begin
      m_e = '0;
      if (m_cnt < 15) m_cnt++;
    end else if (!st) begin
      m_e = d;
      if (d.Valid !== 1'b1 && m_cnt < 15) m_cnt++;
    end
    ex.tag = tag;
    ex.e   = m_e;
    ex.cnt = CNT_W'(m_cnt);
    q.push_back(ex);
    @(posedge clk);
    #1;
    ex = q.pop_front();
    check(ex.tag, ex.e, ex.cnt);
    FlushE = 1'b0;
    StallE = 1'b0;
  endtask

  task automatic rand_d(input logic valid);
    logic [191:0] tmp;
    for (int i = 0; i < 6; i++) tmp[i*32 +: 32] = $urandom();
    d = bundle_t'(tmp[BW-1:0]);
    d.Valid = valid;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", '0, '0);
    rst = 1'b0;

    d = '0; d.RegWrite = 1'b1; d.RD1 = 32'hDEADBEEF; d.Rd = 5'd9; d.Valid = 1'b1;
    step(1'b0, 1'b0, "preload");

    #1 rst = 1'b1;
    #1;
    m_e = '0; m_cnt = 0;
    check("async_rst", '0, '0);
    #1 rst = 1'b0;

    d = '0; d.RegWrite = 1'b1; d.ALUControl = 3'b000; d.Rs1 = 5'd1; d.Rs2 = 5'd2;
    d.Rd = 5'd3; d.RD1 = 32'd5; d.RD2 = 32'd7; d.PC = 32'h100; d.PCPlus4 = 32'h104;
    d.Valid = 1'b1;
    step(1'b0, 1'b0, "load_add");

    d = '0; d.MemWrite = 1'b1; d.ALUSrc = 1'b1; d.ImmExt = 32'd8; d.Rs1 = 5'd2;
    d.Rs2 = 5'd5; d.RD1 = 32'h2000; d.RD2 = 32'hCAFE; d.PC = 32'h104; d.Valid = 1'b1;
    step(1'b0, 1'b0, "load_sw");
    for (int i = 0; i < 3; i++) begin
      rand_d(i[0]);
      step(1'b0, 1'b1, $sformatf("stall%0d", i));
    end
    d = 'x;
    step(1'b0, 1'b1, "stall_xin");

    d = '0; d.Branch = 1'b1; d.ALUControl = 3'b001; d.Rs1 = 5'd4; d.Rs2 = 5'd6;
    d.ImmExt = 32'hFFFF_FFF0; d.PC = 32'h108; d.Valid = 1'b1;
    step(1'b0, 1'b0, "load_beq");
    d = 'x;
    step(1'b1, 1'b0, "flush");

    d = '0; d.Jump = 1'b1; d.ResultSrc = 2'b10; d.RegWrite = 1'b1; d.Rd = 5'd1;
    d.PC = 32'h10C; d.PCPlus4 = 32'h110; d.ImmExt = 32'h40; d.Valid = 1'b1;
    step(1'b0, 1'b0, "load_jal");

    rand_d(1'b1);
    step(1'b1, 1'b1, "flush_stall");

    rand_d(1'b0);
    step(1'b0, 1'b0, "implicit_bubble");
    rand_d(1'b0);
    step(1'b0, 1'b1, "stall_invalid");

    for (int i = 0; i < 20; i++) begin
      rand_d(1'b1);
      step(1'b1, 1'b0, $sformatf("sat%0d", i));
    end
    rand_d(1'b1);
    step(1'b0, 1'b0, "load_after_sat");
    rand_d(1'b0);
    step(1'b0, 1'b0, "bubble_at_sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
